// File: rtl/microtile_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : microtile_rr_sched_if
// Description : Bundle between the requesters, the microtile round-robin
//               scheduler and the shared microtile. The master modport is the
//               scheduler side: it owns grant, tile drive, response and busy.
//               The slave modport is the environment side: requests, operands
//               and the tile output.
// Revision    : 1.0 - initial release
// ============================================================================
interface microtile_rr_sched_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  tile_ui;
    logic [7:0]  tile_uo;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;

    modport master (
        input  req,
        input  req_data,
        input  tile_uo,
        output gnt,
        output tile_ui,
        output rsp_valid,
        output rsp_id,
        output rsp_data,
        output busy
    );

    modport slave (
        output req,
        output req_data,
        output tile_uo,
        input  gnt,
        input  tile_ui,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/microtile_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : microtile_rr_sched
// Description : Round-robin scheduler sharing one microtile between four
//               requesters. A grant latches the winner's operand onto tile_ui,
//               waits TILE_LAT cycles, captures tile_uo and returns it with the
//               winner's index. Legal TILE_LAT range is 1..7.
// Revision    : 1.0 - initial release
// ============================================================================
module microtile_rr_sched #(
    parameter int TILE_LAT = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    microtile_rr_sched_if.master bus
);

    localparam logic     STATE_IDLE  = 1'b0;
    localparam logic     STATE_DRIVE = 1'b1;
    // Counter starts at TILE_LAT-1 so the capture edge closes cycle G+TILE_LAT-1.
    localparam logic [2:0] CNT_LOAD  = 3'(TILE_LAT - 1);

    logic       state;
    logic       state_nxt;
    logic [2:0] cnt;
    logic [1:0] ptr;
    logic [1:0] cur_id;
    logic       win_vld;
    logic [1:0] win_id;

    logic [3:0] gnt_q;
    logic [7:0] tile_ui_q;
    logic       rsp_valid_q;
    logic [1:0] rsp_id_q;
    logic [7:0] rsp_data_q;

    assign bus.gnt       = gnt_q;
    assign bus.tile_ui   = tile_ui_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

    // Circular search for the first asserted request starting at the pointer.
    always_comb begin
        win_vld = 1'b0;
        win_id  = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!win_vld && bus.req[2'(ptr + 2'(k))]) begin
                win_vld = 1'b1;
                win_id  = 2'(ptr + 2'(k));
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave IDLE on any request, leave DRIVE when the count expires.
    always_comb begin
        state_nxt = state;
        case (state)
            STATE_IDLE:  if (win_vld)       state_nxt = STATE_DRIVE;
            STATE_DRIVE: if (cnt == 3'd0)   state_nxt = STATE_IDLE;
            default:                        state_nxt = STATE_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        bus.busy = (state == STATE_DRIVE);
    end

    // Grant, operand latch, latency count and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= 4'b0000;
            tile_ui_q   <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
            rsp_data_q  <= 8'h00;
            cnt         <= 3'd0;
            ptr         <= 2'd0;
            cur_id      <= 2'd0;
        end else begin
            gnt_q       <= 4'b0000;
            rsp_valid_q <= 1'b0;
            if (state == STATE_IDLE) begin
                if (win_vld) begin
                    gnt_q     <= 4'b0001 << win_id;
                    tile_ui_q <= bus.req_data[{win_id, 3'b000} +: 8];
                    cnt       <= CNT_LOAD;
                    cur_id    <= win_id;
                    ptr       <= win_id + 2'd1;
                end
            end else begin
                // Requests are not looked at here, so DRIVE ignores req changes.
                if (cnt == 3'd0) begin
                    rsp_data_q  <= bus.tile_uo;
                    rsp_id_q    <= cur_id;
                    rsp_valid_q <= 1'b1;
                    tile_ui_q   <= 8'h00;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_microtile_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_microtile_rr_sched
// Description : Scoreboard bench for microtile_rr_sched at TILE_LAT 2, 1 and 7.
//               Stimulus pushes expected grants/responses (with their cycle)
//               into queues; per-instance monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microtile_rr_sched;

    typedef struct packed {
        logic [1:0] dut;
        int         cyc;
        logic [3:0] gnt;
        logic [7:0] ui;
    } gexp_t;

    typedef struct packed {
        logic [1:0] dut;
        int         cyc;
        logic [1:0] id;
        logic [7:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    gexp_t      gq[$];
    rexp_t      rq[$];
    logic [7:0] cur_ui [3];

    microtile_rr_sched_if bus0 ();
    microtile_rr_sched_if bus1 ();
    microtile_rr_sched_if bus2 ();

    // Main instance sees a tile that inverts its input.
    assign bus0.tile_uo = ~bus0.tile_ui;

    microtile_rr_sched #(.TILE_LAT(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    microtile_rr_sched #(.TILE_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
    microtile_rr_sched #(.TILE_LAT(7)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic [1:0] d, input int c, input logic [3:0] g, input logic [7:0] u);
        gexp_t e;
        e.dut = d; e.cyc = c; e.gnt = g; e.ui = u;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic [1:0] d, input int c, input logic [1:0] id, input logic [7:0] data);
        rexp_t e;
        e.dut = d; e.cyc = c; e.id = id; e.data = data;
        rq.push_back(e);
    endtask

    task automatic mon(input int k, input logic [3:0] g, input logic [7:0] ui, input logic b,
                       input logic rv, input logic [1:0] id, input logic [7:0] d);
        gexp_t ge;
        rexp_t re;
        if (g !== 4'b0000) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", {28'd0, g}, 32'd0);
            end else begin
                ge = gq.pop_front();
                chk("gnt_dut",     k,  {30'd0, ge.dut});
                chk("gnt_value",   {28'd0, g},  {28'd0, ge.gnt});
                chk("gnt_cycle",   cyc, ge.cyc);
                chk("gnt_tile_ui", {24'd0, ui}, {24'd0, ge.ui});
                chk("gnt_busy",    {31'd0, b},  32'd1);
                cur_ui[k] = ge.ui;
            end
        end else if (b === 1'b1) begin
            chk("hold_tile_ui", {24'd0, ui}, {24'd0, cur_ui[k]});
        end else begin
            chk("idle_tile_ui", {24'd0, ui}, 32'd0);
        end
        if (rv !== 1'b0) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rv}, 32'd0);
            end else begin
                re = rq.pop_front();
                chk("rsp_dut",   k,   {30'd0, re.dut});
                chk("rsp_cycle", cyc, re.cyc);
                chk("rsp_id",    {30'd0, id}, {30'd0, re.id});
                chk("rsp_data",  {24'd0, d},  {24'd0, re.data});
            end
        end
    endtask

    // One monitor per instance, sampling mid-cycle.
    always @(negedge clk) mon(0, bus0.gnt, bus0.tile_ui, bus0.busy, bus0.rsp_valid, bus0.rsp_id, bus0.rsp_data);
    always @(negedge clk) mon(1, bus1.gnt, bus1.tile_ui, bus1.busy, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data);
    always @(negedge clk) mon(2, bus2.gnt, bus2.tile_ui, bus2.busy, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_data);

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         c;
        logic [7:0] u;

        rst_n = 1'b0;
        bus0.req = 4'b0000; bus0.req_data = 32'h0;
        bus1.req = 4'b0000; bus1.req_data = 32'h0; bus1.tile_uo = 8'h00;
        bus2.req = 4'b0000; bus2.req_data = 32'h0; bus2.tile_uo = 8'h00;
        tick(2);

        // Reset state.
        chk("reset_gnt",       {28'd0, bus0.gnt},       32'd0);
        chk("reset_tile_ui",   {24'd0, bus0.tile_ui},   32'd0);
        chk("reset_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
        chk("reset_rsp_id",    {30'd0, bus0.rsp_id},    32'd0);
        chk("reset_rsp_data",  {24'd0, bus0.rsp_data},  32'd0);
        chk("reset_busy",      {31'd0, bus0.busy},      32'd0);

        // Single request; operand and request change during DRIVE are ignored.
        c = cyc;
        bus0.req = 4'b0001; bus0.req_data = 32'h0000_00A5;
        push_g(0, c + 1, 4'b0001, 8'hA5);
        push_r(0, c + 3, 2'd0, 8'h5A);
        rst_n = 1'b1;
        tick(1);
        bus0.req = 4'b0000; bus0.req_data = 32'hFFFF_FFFF;
        tick(5);

        // All four requesting from reset: order 0,1,2,3,0, three cycles apart.
        rst_n = 1'b0;
        tick(2);
        c = cyc;
        bus0.req = 4'b1111; bus0.req_data = 32'h4433_2211;
        for (int i = 0; i < 5; i++) begin
            u = 8'((i % 4 + 1) * 17);
            push_g(0, c + 1 + 3 * i, 4'b0001 << (i % 4), u);
            push_r(0, c + 3 + 3 * i, 2'(i % 4), ~u);
        end
        rst_n = 1'b1;
        tick(13);
        bus0.req = 4'b0000;
        tick(5);

        // Pointer wrap: grant 3, then 1001 -> 0, then 0011 -> 1, then 0001 from ptr 2 -> 0.
        c = cyc;
        bus0.req = 4'b1000; bus0.req_data = 32'hD4C3_B2A1;
        push_g(0, c + 1, 4'b1000, 8'hD4);  push_r(0, c + 3,  2'd3, 8'h2B);
        push_g(0, c + 4, 4'b0001, 8'hA1);  push_r(0, c + 6,  2'd0, 8'h5E);
        push_g(0, c + 7, 4'b0010, 8'hB2);  push_r(0, c + 9,  2'd1, 8'h4D);
        push_g(0, c + 10, 4'b0001, 8'hA1); push_r(0, c + 12, 2'd0, 8'h5E);
        tick(1);
        bus0.req = 4'b1001;
        tick(3);
        bus0.req = 4'b0011;
        tick(3);
        bus0.req = 4'b0001;
        tick(3);
        bus0.req = 4'b0000;
        tick(5);

        // Reset in cycle G+1 aborts the operation; held request is granted on release.
        c = cyc;
        bus0.req = 4'b0100; bus0.req_data = 32'h0077_0000;
        push_g(0, c + 1, 4'b0100, 8'h77);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("async_gnt",       {28'd0, bus0.gnt},       32'd0);
        chk("async_tile_ui",   {24'd0, bus0.tile_ui},   32'd0);
        chk("async_busy",      {31'd0, bus0.busy},      32'd0);
        chk("async_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
        chk("async_rsp_data",  {24'd0, bus0.rsp_data},  32'd0);
        tick(2);
        c = cyc;
        push_g(0, c + 1, 4'b0100, 8'h77); push_r(0, c + 3, 2'd2, 8'h88);
        push_g(0, c + 4, 4'b0100, 8'h77); push_r(0, c + 6, 2'd2, 8'h88);
        rst_n = 1'b1;
        tick(4);
        bus0.req = 4'b0000;
        tick(5);

        // TILE_LAT=1: sample at the end of the grant cycle only.
        c = cyc;
        bus1.req = 4'b0010; bus1.req_data = 32'h0000_C300; bus1.tile_uo = 8'h11;
        push_g(1, c + 1, 4'b0010, 8'hC3);
        push_r(1, c + 2, 2'd1, 8'h5E);
        tick(1);
        bus1.req = 4'b0000; bus1.tile_uo = 8'h5E;
        tick(1);
        bus1.tile_uo = 8'hE7;
        tick(4);

        // TILE_LAT=7: sample at the end of cycle G+6 only.
        c = cyc;
        bus2.req = 4'b1000; bus2.req_data = 32'h9C00_0000; bus2.tile_uo = 8'h00;
        push_g(2, c + 1, 4'b1000, 8'h9C);
        push_r(2, c + 8, 2'd3, 8'h6B);
        tick(1);
        bus2.req = 4'b0000; bus2.tile_uo = 8'h12;
        tick(6);
        bus2.tile_uo = 8'h6B;
        tick(1);
        bus2.tile_uo = 8'hF0;
        tick(4);

        chk("pending_gnt", gq.size(), 32'd0);
        chk("pending_rsp", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
